sync_mem_responder: RTL and testbench

SYNC_MEM_RESPONDER -- requirements
Module: sync_mem_responder

---
 rtl/mem_resp_pkg.sv | 18 +
 rtl/mem_access_decode.sv | 42 ++++
 rtl/sync_mem_responder.sv | 130 +++++++++++++
 tb/tb_sync_mem_responder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared opcode constants, FSM state and access-size encodings for the
// synchronous memory responder.
package mem_resp_pkg;

    localparam logic [5:0] OPC_LB  = 6'b100000;
    localparam logic [5:0] OPC_LBU = 6'b100100;
    localparam logic [5:0] OPC_LH  = 6'b100001;
    localparam logic [5:0] OPC_LHU = 6'b100101;
    localparam logic [5:0] OPC_LW  = 6'b100011;
    localparam logic [5:0] OPC_SB  = 6'b101000;
    localparam logic [5:0] OPC_SH  = 6'b101001;
    localparam logic [5:0] OPC_SW  = 6'b101011;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    typedef enum logic [1:0] {BYTE, HALF, WORD} size_t;

endpackage

// File: rtl/mem_access_decode.sv
// Combinational decode of a latched request into access size, sign
// extension, write enable and rejection.
module mem_access_decode
    import mem_resp_pkg::*;
(
    input  logic [5:0] opc,
    input  logic       rw,
    input  logic [1:0] addr_lo,
    output size_t      size,
    output logic       sign_ext,
    output logic       write_en,
    output logic       err
);

    logic known;
    logic is_store;
    logic misaligned;

    always_comb begin
        size     = BYTE;
        sign_ext = 1'b0;
        is_store = 1'b0;
        known    = 1'b1;
        case (opc)
            OPC_LB:  begin size = BYTE; sign_ext = 1'b1; end
            OPC_LBU: size = BYTE;
            OPC_LH:  begin size = HALF; sign_ext = 1'b1; end
            OPC_LHU: size = HALF;
            OPC_LW:  size = WORD;
            OPC_SB:  begin size = BYTE; is_store = 1'b1; end
            OPC_SH:  begin size = HALF; is_store = 1'b1; end
            OPC_SW:  begin size = WORD; is_store = 1'b1; end
            default: known = 1'b0;
        endcase
        misaligned = ((size == HALF) && addr_lo[0]) ||
                     ((size == WORD) && (addr_lo != 2'b00));
        // RW=1 means read, so a store opcode with RW=1 (or load with RW=0) disagrees
        err      = !known || (is_store == rw) || misaligned;
        write_en = is_store && !err;
    end

endmodule

// File: rtl/sync_mem_responder.sv
// Byte-addressed big-endian memory with a fixed wait-state count and a
// four-phase MOV/MOC handshake.
module sync_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned DEPTH       = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MOV,
    input  logic        RW,
    input  logic [8:0]  Address,
    input  logic [5:0]  OpC,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        MOC,
    output logic        ERR,
    output logic        BUSY
);

    logic [7:0]  Mem [0:DEPTH-1];

    state_t      state;
    logic [3:0]  count;
    logic [8:0]  addr_q;
    logic        rw_q;
    logic [5:0]  opc_q;
    logic [31:0] data_q;

    size_t       size;
    logic        sign_ext;
    logic        write_en;
    logic        err;
    logic        complete;
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] load_data;

    mem_access_decode u_decode (
        .opc      (opc_q),
        .rw       (rw_q),
        .addr_lo  (addr_q[1:0]),
        .size     (size),
        .sign_ext (sign_ext),
        .write_en (write_en),
        .err      (err)
    );

    assign complete = (state == WAIT) && (count == '0);

    always_comb begin
        b0 = Mem[addr_q];
        b1 = Mem[addr_q + 9'd1];
        b2 = Mem[addr_q + 9'd2];
        b3 = Mem[addr_q + 9'd3];
        case (size)
            BYTE:    load_data = {{24{sign_ext & b0[7]}}, b0};
            HALF:    load_data = {{16{sign_ext & b0[7]}}, b0, b1};
            default: load_data = {b0, b1, b2, b3};
        endcase
    end

    // Storage has no reset; reset only suppresses a write on the completing edge
    always_ff @(posedge clk) begin
        if (!reset && complete && write_en) begin
            case (size)
                BYTE: Mem[addr_q] <= data_q[7:0];
                HALF: begin
                    Mem[addr_q]        <= data_q[15:8];
                    Mem[addr_q + 9'd1] <= data_q[7:0];
                end
                default: begin
                    Mem[addr_q]        <= data_q[31:24];
                    Mem[addr_q + 9'd1] <= data_q[23:16];
                    Mem[addr_q + 9'd2] <= data_q[15:8];
                    Mem[addr_q + 9'd3] <= data_q[7:0];
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            MOC     <= 1'b0;
            ERR     <= 1'b0;
            BUSY    <= 1'b0;
            DataOut <= '0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            opc_q   <= '0;
            data_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (MOV) begin
                        addr_q <= Address;
                        rw_q   <= RW;
                        opc_q  <= OpC;
                        data_q <= DataIn;
                        count  <= 4'(WAIT_CYCLES);
                        BUSY   <= 1'b1;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (count != '0) begin
                        count <= count - 4'd1;
                    end else begin
                        MOC     <= 1'b1;
                        ERR     <= err;
                        DataOut <= (err || !rw_q) ? '0 : load_data;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (!MOV) begin
                        MOC   <= 1'b0;
                        ERR   <= 1'b0;
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sync_mem_responder.sv
// Directed bench for sync_mem_responder: byte-array model plus per-cycle
// output comparison and literal checks on key results.
module tb_sync_mem_responder;

    localparam int W = 2;

    localparam logic [5:0] LB  = 6'b100000;
    localparam logic [5:0] LBU = 6'b100100;
    localparam logic [5:0] LH  = 6'b100001;
    localparam logic [5:0] LHU = 6'b100101;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] SB  = 6'b101000;
    localparam logic [5:0] SH  = 6'b101001;
    localparam logic [5:0] SW  = 6'b101011;

    logic        clk = 1'b0;
    logic        reset;
    logic        MOV;
    logic        RW;
    logic [8:0]  Address;
    logic [5:0]  OpC;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        MOC;
    logic        ERR;
    logic        BUSY;

    int n_checks = 0;
    int n_fail   = 0;

    logic        chk_en = 1'b0;
    logic        exp_moc, exp_err, exp_busy, exp_dv;
    logic [31:0] exp_dout;
    logic [7:0]  mdl [0:511];

    sync_mem_responder #(.WAIT_CYCLES(W), .DEPTH(512)) dut (
        .clk     (clk),
        .reset   (reset),
        .MOV     (MOV),
        .RW      (RW),
        .Address (Address),
        .OpC     (OpC),
        .DataIn  (DataIn),
        .DataOut (DataOut),
        .MOC     (MOC),
        .ERR     (ERR),
        .BUSY    (BUSY)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Access semantics straight from the opcode table: size, signedness,
    // direction, alignment, big-endian byte order.
    function automatic void model_access(input logic [5:0] opc, input logic rw,
                                         input logic [8:0] a, input logic [31:0] din,
                                         output logic e, output logic [31:0] d);
        int nb = 1;
        bit sgn = 0, is_load = 1, known = 1;
        logic [31:0] v = 0;
        case (opc)
            LB:  begin nb = 1; sgn = 1; end
            LBU: nb = 1;
            LH:  begin nb = 2; sgn = 1; end
            LHU: nb = 2;
            LW:  nb = 4;
            SB:  begin nb = 1; is_load = 0; end
            SH:  begin nb = 2; is_load = 0; end
            SW:  begin nb = 4; is_load = 0; end
            default: known = 0;
        endcase
        e = !known || (is_load != rw) || ((int'(a) % nb) != 0);
        d = 0;
        if (!e) begin
            if (is_load) begin
                for (int i = 0; i < nb; i++) v = (v << 8) | 32'(mdl[int'(a) + i]);
                if (sgn && v[8*nb-1]) v = v | ~((32'h1 << (8*nb)) - 32'h1);
                d = v;
            end else begin
                for (int i = 0; i < nb; i++) mdl[int'(a) + i] = 8'(din >> (8*(nb-1-i)));
            end
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("MOC", 32'(MOC), 32'(exp_moc));
            check("ERR", 32'(ERR), 32'(exp_err));
            check("BUSY", 32'(BUSY), 32'(exp_busy));
            if (exp_dv) check("DataOut", DataOut, exp_dout);
        end
    end

    task automatic txn(input logic [5:0] opc, input logic rw, input logic [8:0] a,
                       input logic [31:0] din, input int hold,
                       output logic [31:0] got, output logic got_err);
        logic e;
        logic [31:0] d;
        @(negedge clk);
        MOV = 1'b1; RW = rw; OpC = opc; Address = a; DataIn = din;
        @(posedge clk);
        exp_busy = 1'b1; exp_dv = 1'b0;
        // Inputs are garbage after acceptance; the latched request must win
        @(negedge clk);
        Address = ~a; DataIn = ~din; OpC = 6'b000000; RW = ~rw;
        repeat (W) @(posedge clk);
        @(posedge clk);
        model_access(opc, rw, a, din, e, d);
        exp_moc = 1'b1; exp_err = e; exp_dout = d; exp_dv = 1'b1;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        got = DataOut; got_err = ERR;
        MOV = 1'b0;
        @(posedge clk);
        exp_moc = 1'b0; exp_err = 1'b0; exp_busy = 1'b0; exp_dv = 1'b0;
    endtask

    task automatic expect_reset_state();
        exp_moc = 1'b0; exp_err = 1'b0; exp_busy = 1'b0;
        exp_dout = '0; exp_dv = 1'b1;
    endtask

    task automatic check_mem(input int a, input logic [7:0] v);
        check($sformatf("Mem[%0d]", a), 32'(dut.Mem[a]), 32'(v));
    endtask

    initial begin
        logic [31:0] got;
        logic        ge;

        reset = 1'b1; MOV = 1'b0; RW = 1'b0; OpC = '0; Address = '0; DataIn = '0;
        for (int i = 0; i < 512; i++) mdl[i] = 8'h00;
        expect_reset_state();
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        txn(SW, 1'b0, 9'd0,  32'h12345678, 0, got, ge);
        check("SW0 DataOut", got, 32'h0);
        txn(SW, 1'b0, 9'd4,  32'h11223344, 0, got, ge);
        txn(SW, 1'b0, 9'd8,  32'h55667788, 0, got, ge);
        txn(SW, 1'b0, 9'd12, 32'h99AABBCC, 0, got, ge);

        txn(LW, 1'b1, 9'd0, 32'h0, 0, got, ge);
        check("LW0", got, 32'h12345678);
        check("LW0 ERR", 32'(ge), 32'h0);

        txn(SB, 1'b0, 9'd3, 32'hFFFFFF80, 0, got, ge);
        txn(LB, 1'b1, 9'd3, 32'h0, 0, got, ge);
        check("LB3", got, 32'hFFFFFF80);
        txn(LBU, 1'b1, 9'd3, 32'h0, 0, got, ge);
        check("LBU3", got, 32'h00000080);

        txn(SB, 1'b0, 9'd2, 32'h00000080, 0, got, ge);
        txn(SB, 1'b0, 9'd3, 32'h00000001, 0, got, ge);
        txn(LH, 1'b1, 9'd2, 32'h0, 0, got, ge);
        check("LH2", got, 32'hFFFF8001);
        txn(LHU, 1'b1, 9'd2, 32'h0, 0, got, ge);
        check("LHU2", got, 32'h00008001);

        txn(SH, 1'b0, 9'd6, 32'hAABBCCDD, 0, got, ge);
        check("SH6 ERR", 32'(ge), 32'h0);
        check_mem(4, 8'h11); check_mem(5, 8'h22);
        check_mem(6, 8'hCC); check_mem(7, 8'hDD); check_mem(8, 8'h55);

        txn(LW, 1'b1, 9'd2, 32'h0, 0, got, ge);
        check("LW2 ERR", 32'(ge), 32'h1);
        check("LW2 DataOut", got, 32'h0);
        txn(SW, 1'b0, 9'd5, 32'hFEEDFACE, 0, got, ge);
        check("SW5 ERR", 32'(ge), 32'h1);
        check_mem(4, 8'h11); check_mem(5, 8'h22);
        check_mem(6, 8'hCC); check_mem(7, 8'hDD); check_mem(8, 8'h55);

        txn(6'b111111, 1'b1, 9'd0, 32'h0, 0, got, ge);
        check("BADOPC ERR", 32'(ge), 32'h1);
        txn(SB, 1'b1, 9'd0, 32'h000000EE, 0, got, ge);
        check("SB RW=1 ERR", 32'(ge), 32'h1);
        check_mem(0, 8'h12);

        // Reset one edge into WAIT: access abandoned
        @(negedge clk);
        MOV = 1'b1; RW = 1'b0; OpC = SW; Address = 9'd8; DataIn = 32'hDEADBEEF;
        @(posedge clk);
        exp_busy = 1'b1; exp_dv = 1'b0;
        @(negedge clk);
        reset = 1'b1; MOV = 1'b0;
        @(posedge clk);
        expect_reset_state();
        @(negedge clk);
        reset = 1'b0;
        repeat (W + 3) @(posedge clk);
        check_mem(8, 8'h55); check_mem(9, 8'h66); check_mem(10, 8'h77); check_mem(11, 8'h88);

        // Reset coincides with the completing edge
        @(negedge clk);
        MOV = 1'b1; RW = 1'b0; OpC = SW; Address = 9'd12; DataIn = 32'h0BADF00D;
        @(posedge clk);
        exp_busy = 1'b1; exp_dv = 1'b0;
        repeat (W) @(posedge clk);
        @(negedge clk);
        reset = 1'b1; MOV = 1'b0;
        @(posedge clk);
        expect_reset_state();
        @(negedge clk);
        reset = 1'b0;
        repeat (W + 3) @(posedge clk);
        check_mem(12, 8'h99); check_mem(13, 8'hAA); check_mem(14, 8'hBB); check_mem(15, 8'hCC);

        // Reset together with a fresh request
        @(negedge clk);
        reset = 1'b1; MOV = 1'b1; RW = 1'b0; OpC = SW; Address = 9'd0; DataIn = 32'h0;
        @(posedge clk);
        expect_reset_state();
        @(negedge clk);
        reset = 1'b0; MOV = 1'b0;
        repeat (W + 3) @(posedge clk);
        check_mem(0, 8'h12);

        txn(LW, 1'b1, 9'd0, 32'h0, 4, got, ge);
        check("LW0 hold4", got, 32'h12348001);

        txn(SW, 1'b0, 9'd508, 32'hCAFEF00D, 0, got, ge);
        txn(LW, 1'b1, 9'd508, 32'h0, 0, got, ge);
        check("LW508", got, 32'hCAFEF00D);

        for (int i = 0; i < 16; i++) check_mem(i, mdl[i]);
        for (int i = 508; i < 512; i++) check_mem(i, mdl[i]);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
